// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch block: opcodes, FSM states,
// instruction field positions and a HALT detector.
package ifetch_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE
    } state_t;

    function automatic logic isHalt(input logic [7:0] instr);
        return instr[OPC_HI:OPC_LO] == OP_HALT;
    endfunction

endpackage

// File: rtl/ifetch_mem.sv
// Program store: DEPTH x 8 register array, one synchronous write port and
// one combinational read port. Deliberately not reset.
module ifetch_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [7:0]        i_wrData,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [7:0]        o_rdData
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch sequencer feeding simple_cpu. Define IFETCH_LOOP_EN to wrap from the
// last program word back to address 0 instead of finishing.
module instr_fetch #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              start,
    input  logic              abort,
    input  logic              cpu_ready,
    output logic [7:0]        instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);

    import ifetch_pkg::*;

`ifdef IFETCH_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    state_t            r_state;
    logic [7:0]        r_instr;
    logic [ADDR_W-1:0] r_pc;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;

    logic              w_wrEn;
    logic [ADDR_W-1:0] w_nextPc;
    logic [ADDR_W-1:0] w_rdAddr;
    logic [7:0]        w_rdData;

    // The single read port serves both the start fetch (address 0) and the
    // look-ahead fetch of pc+1 while issuing.
    assign w_wrEn   = load_en && (r_state != S_ISSUE);
    assign w_nextPc = r_pc + ADDR_W'(1);
    assign w_rdAddr = (r_state == S_ISSUE) ? w_nextPc : '0;

    ifetch_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk    (clk),
        .i_wrEn   (w_wrEn),
        .i_wrAddr (load_addr),
        .i_wrData (load_data),
        .i_rdAddr (w_rdAddr),
        .o_rdData (w_rdData)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_instr <= 8'h00;
            r_pc    <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_instr <= 8'h00;
            r_pc    <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // A write in the same cycle takes precedence over start.
                    if (start && !load_en) begin
                        if (isHalt(w_rdData)) begin
                            r_state <= S_DONE;
                            r_instr <= 8'h00;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                            r_instr <= w_rdData;
                            r_pc    <= '0;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (cpu_ready) begin
                        if ((r_pc == ADDR_W'(DEPTH - 1) && !LOOP_EN) || isHalt(w_rdData)) begin
                            r_state <= S_DONE;
                            r_instr <= 8'h00;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_pc    <= w_nextPc;
                            r_instr <= w_rdData;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_instr <= 8'h00;
                    r_pc    <= '0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign instruction = r_instr;
    assign instr_valid = r_valid;
    assign pc          = r_pc;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Program store and fetch sequencer sitting directly upstream of `simple_cpu`. It holds a small program of 8-bit instructions: opcode in bits [7:4], immediate in bits [3:0]. A host loads the program through a write port; on `start` the block presents instructions one per handshake on `instruction`, which drives the CPU's `instruction` input. Sequencing stops at a HALT opcode, at end of memory, or on `abort`.

## Interface
- `DEPTH`, 16: program words; must be a power of two, at least 2.
- `ADDR_W`, 4: address width; equals log2(DEPTH).
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `load_en` input 1: write strobe for the program store.
- `load_addr` input ADDR_W: write address.
- `load_data` input 8: write data.
- `start` input 1: begin fetch at address 0.
- `abort` input 1: return to IDLE.
- `cpu_ready` input 1: consumer accepts `instruction` this cycle; tie high for `simple_cpu`.
- `instruction` output 8: presented instruction; drives `simple_cpu.instruction`.
- `instr_valid` output 1: `instruction` is meaningful.
- `pc` output ADDR_W: address of the presented instruction.
- `busy` output 1: state is ISSUE.
- `done` output 1: state is DONE.

## Operation
- **States:** IDLE, ISSUE, DONE.
- **Reset values:** state IDLE, `instruction`=8'h00, `instr_valid`=0, `pc`=0, `busy`=0, `done`=0. Program store is not reset.
- **Writes:** `load_en` writes `load_data` to `mem[load_addr]` only in IDLE or DONE; ignored in ISSUE.
- **IDLE/DONE, `start` with `load_en` low:**
  - If `mem[0][7:4]`=4'hF (HALT): go to DONE.
  - Otherwise: go to ISSUE with `instruction`=`mem[0]` and `pc`=0.
- **`start` with `load_en` high:** the write commits; `start` is ignored.
- **Transfer:** `instr_valid` && `cpu_ready` on a rising edge. `instr_valid` is high exactly in ISSUE.
- **In ISSUE, no transfer:** `instruction` and `pc` hold.
- **In ISSUE, on transfer:** next address n = `pc`+1 (ADDR_W bits).
  - If `pc`=DEPTH-1 and looping is disabled: go to DONE.
  - Else if `mem[n][7:4]`=4'hF: go to DONE; HALT is never presented.
  - Else: `pc`<=n, `instruction`<=`mem[n]`.
- **Entering DONE:** `instruction` is cleared to 8'h00 (NOP). `pc` holds the last issued address.
- **`abort`:** highest priority over start, transfer, and writes to state. From any state, go to IDLE next cycle with `instruction`=0 and `pc`=0. A write in the same cycle still commits if the block was in IDLE or DONE.
- **Opcodes:** not decoded except HALT; all other opcodes pass through unchanged.

## Timing
- **Start to first valid:** 1 cycle. `start` sampled at edge k gives `instr_valid`=1 after edge k.
- **Throughput:** one instruction per cycle with `cpu_ready` held high.
- **Outputs:** all registered; no combinational path from inputs to outputs.
- **Write to read:** a write at edge k is visible to a fetch at edge k+1 or later.
- **Reset mid-ISSUE:** outputs clear immediately (asynchronous). Fetch resumes only on a new `start` after `reset` deasserts.

## Configuration
- `IFETCH_LOOP_EN`
  - **Defined:** a transfer at `pc`=DEPTH-1 wraps to address 0 and continues. Only HALT or `abort` ends the run.
  - **Undefined:** a transfer at `pc`=DEPTH-1 ends in DONE.

## Structure
- **Package `ifetch_pkg`:**
  - Opcode constants: OP_NOP=4'h0, OP_LDI=4'h1, OP_ADD=4'h2, OP_SUB=4'h3, OP_HALT=4'hF.
  - State enum.
  - Instruction field slice constants: OPC_HI=7, OPC_LO=4.
- **Sub-module `ifetch_mem`:** DEPTH×8 register array with one synchronous write port and one combinational read port. It has no reset.
- **Top level:** FSM, PC, and output registers.

## Test plan
- **Basic run:** load 8'h15, 8'h23, 8'h32, 8'hF0 at addresses 0–3; pulse `start` with `cpu_ready`=1. Expect `instruction`=15, 23, 32 on three consecutive cycles with `pc`=0, 1, 2. Then `done`=1, `instr_valid`=0, `instruction`=00. Downstream `acc` ends at 6.
- **Backpressure:** same program with `cpu_ready` low for 3 cycles after the first valid. Expect 8'h15 and `pc`=0 held stable for all 3 cycles; sequence resumes when ready rises.
- **End of memory:** fill all 16 words with 8'h21.
  - Without `IFETCH_LOOP_EN`: 16 transfers, then DONE.
  - With it: transfer 17 presents `pc`=0.
- **Immediate HALT:** `mem[0]`=8'hF0, `start`. Expect DONE next cycle; `instr_valid` never rises.
- **Abort and reset:** assert `abort` at `pc`=1, and separately drop `reset` at `pc`=1. Expect IDLE with all outputs 0. For `abort`, this happens at the next edge; for `reset`, immediately. A new `start` restarts at `pc`=0 with 8'h15.
- **Write gating:** `load_en` during ISSUE to address 2 with 8'h11 leaves `mem[2]`=8'h32 on the next run. `load_en` in the same cycle as `start` writes but does not start.
